urv_trap_ctrl: RTL and testbench

Machine-mode trap sequencer for the uRV core. It owns mstatus, mie, mip, mepc and mcause, and feeds their read values into the CSR datapath. It accepts CSR write values from the datapath and samples exceptions, interrupts and mret at the execute stage. On a trap or mret it issues a one-cycle fetch redirect, then blocks new events for a programmable flush window.

---
 rtl/urv_trap_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_urv_trap_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_trap_ctrl.sv
// urv_trap_ctrl: machine-mode trap sequencer for the uRV core.
// Owns mstatus/mie/mip/mepc/mcause. On a trap or mret it issues a one-cycle
// fetch redirect, then refuses new events for FLUSH_CYCLES cycles.
// Optional feature macro: URV_TIMER_IRQ_EN (MTIE/MTIP and timer interrupts).
module urv_trap_ctrl #(
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0008,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic [31:0] d_pc_i,
  input  logic        d_is_csr_i,
  input  logic [11:0] d_csr_sel_i,
  input  logic [31:0] x_csr_write_value_i,
  input  logic        d_is_mret_i,
  input  logic        x_exception_i,
  input  logic [3:0]  x_exception_cause_i,
  input  logic        irq_i,
  input  logic        timer_tick_i,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic        x_redirect_o,
  output logic [31:0] x_redirect_pc_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_redirect;
  logic [31:0]      r_redirect_pc;

  logic             r_mstatus_mie;
  logic             r_mstatus_mpie;
  logic             r_mie_meie;
  logic [29:0]      r_mepc;
  logic             r_mcause_int;
  logic [3:0]       r_mcause_code;

  logic             w_mtie;
  logic             w_mtip;
  logic             w_accept;
  logic             w_ext_pend;
  logic             w_tmr_pend;
  logic             w_irq_pend;
  logic             w_take_exc;
  logic             w_take_irq;
  logic             w_take_mret;
  logic             w_event;
  logic             w_csr_we;
  logic [3:0]       w_irq_code;

`ifdef URV_TIMER_IRQ_EN
  logic r_mie_mtie;
  logic r_mip_mtip;

  assign w_mtie = r_mie_mtie;
  assign w_mtip = r_mip_mtip;

  // MTIE is a plain CSR bit, only written when the write is not displaced by an event.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mie_mtie <= 1'b0;
    end else if (w_csr_we && (d_csr_sel_i == CSR_MIE)) begin
      r_mie_mtie <= x_csr_write_value_i[7];
    end
  end

  // MTIP is sticky: the tick sets it and beats a same-cycle CSR clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mip_mtip <= 1'b0;
    end else if (timer_tick_i) begin
      r_mip_mtip <= 1'b1;
    end else if (w_csr_we && (d_csr_sel_i == CSR_MIP)) begin
      r_mip_mtip <= x_csr_write_value_i[7];
    end
  end

  logic w_unused;
  assign w_unused = &{1'b0, d_pc_i[1:0]};
`else
  assign w_mtie = 1'b0;
  assign w_mtip = 1'b0;

  logic w_unused;
  assign w_unused = &{1'b0, d_pc_i[1:0], timer_tick_i};
`endif

  // Event arbitration: exception beats interrupt beats mret; a CSR write only lands without an event.
  assign w_accept    = (r_state == S_IDLE) && !x_stall_i && !x_kill_i;
  assign w_ext_pend  = irq_i & r_mie_meie;
  assign w_tmr_pend  = w_mtip & w_mtie;
  assign w_irq_pend  = r_mstatus_mie & (w_ext_pend | w_tmr_pend);
  assign w_irq_code  = w_ext_pend ? 4'd11 : 4'd7;
  assign w_take_exc  = w_accept & x_exception_i;
  assign w_take_irq  = w_accept & ~x_exception_i & w_irq_pend;
  assign w_take_mret = w_accept & ~x_exception_i & ~w_irq_pend & d_is_mret_i;
  assign w_event     = w_take_exc | w_take_irq | w_take_mret;
  assign w_csr_we    = w_accept & d_is_csr_i & ~w_event;

  // Sequencer: IDLE -> REDIRECT (one cycle) -> FLUSH (FLUSH_CYCLES cycles) -> IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state       <= S_IDLE;
      r_flush_cnt   <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_event) begin
            r_state       <= S_REDIRECT;
            r_redirect    <= 1'b1;
            r_redirect_pc <= w_take_mret ? {r_mepc, 2'b00} : TRAP_VECTOR;
          end
        end
        S_REDIRECT: begin
          r_state     <= S_FLUSH;
          r_redirect  <= 1'b0;
          r_flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
        end
        S_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_redirect <= 1'b0;
        end
      endcase
    end
  end

  // CSR state: trap entry and mret take precedence over datapath writes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_meie     <= 1'b0;
      r_mepc         <= '0;
      r_mcause_int   <= 1'b0;
      r_mcause_code  <= '0;
    end else if (w_take_exc || w_take_irq) begin
      r_mepc         <= d_pc_i[31:2];
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
      r_mcause_int   <= w_take_irq;
      r_mcause_code  <= w_take_exc ? x_exception_cause_i : w_irq_code;
    end else if (w_take_mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_csr_we) begin
      case (d_csr_sel_i)
        CSR_MSTATUS: begin
          r_mstatus_mie  <= x_csr_write_value_i[3];
          r_mstatus_mpie <= x_csr_write_value_i[7];
        end
        CSR_MIE:    r_mie_meie    <= x_csr_write_value_i[11];
        CSR_MEPC:   r_mepc        <= x_csr_write_value_i[31:2];
        CSR_MCAUSE: begin
          r_mcause_int  <= x_csr_write_value_i[31];
          r_mcause_code <= x_csr_write_value_i[3:0];
        end
        default: begin
        end
      endcase
    end
  end

  // Read values straight from registers; MEIP follows irq_i live.
  assign csr_mstatus_o   = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
  assign csr_mie_o       = {20'b0, r_mie_meie, 3'b0, w_mtie, 7'b0};
  assign csr_mip_o       = {20'b0, irq_i, 3'b0, w_mtip, 7'b0};
  assign csr_mepc_o      = {r_mepc, 2'b00};
  assign csr_mcause_o    = {r_mcause_int, 27'b0, r_mcause_code};
  assign x_redirect_o    = r_redirect;
  assign x_redirect_pc_o = r_redirect_pc;

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Testbench for urv_trap_ctrl: directed scenarios plus randomized traffic
// checked against a CSR-level reference model (busy-window counter, masks).
module tb_urv_trap_ctrl;

  localparam logic [31:0] TV = 32'h0000_0008;
  localparam int          FC = 2;
`ifdef URV_TIMER_IRQ_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic        clk_i, rst_i;
  logic        x_stall_i, x_kill_i;
  logic [31:0] d_pc_i;
  logic        d_is_csr_i;
  logic [11:0] d_csr_sel_i;
  logic [31:0] x_csr_write_value_i;
  logic        d_is_mret_i, x_exception_i;
  logic [3:0]  x_exception_cause_i;
  logic        irq_i, timer_tick_i;
  logic [31:0] csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o;
  logic        x_redirect_o;
  logic [31:0] x_redirect_pc_o;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic        m_st_mie, m_st_mpie, m_mtip, m_redir;
  logic [31:0] m_mie_r, m_mepc, m_mcause, m_pc;
  int          m_block;

  urv_trap_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
    .d_pc_i(d_pc_i), .d_is_csr_i(d_is_csr_i), .d_csr_sel_i(d_csr_sel_i),
    .x_csr_write_value_i(x_csr_write_value_i),
    .d_is_mret_i(d_is_mret_i), .x_exception_i(x_exception_i),
    .x_exception_cause_i(x_exception_cause_i),
    .irq_i(irq_i), .timer_tick_i(timer_tick_i),
    .csr_mstatus_o(csr_mstatus_o), .csr_mip_o(csr_mip_o), .csr_mie_o(csr_mie_o),
    .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o),
    .x_redirect_o(x_redirect_o), .x_redirect_pc_o(x_redirect_pc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic void model_reset();
    m_st_mie = 1'b0; m_st_mpie = 1'b0; m_mtip = 1'b0; m_redir = 1'b0;
    m_mie_r = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_pc = 32'h0;
    m_block = 0;
  endfunction

  function automatic logic [31:0] mip_word();
    mip_word = 32'h0;
    if (irq_i)  mip_word = mip_word | 32'h800;
    if (m_mtip) mip_word = mip_word | 32'h80;
  endfunction

  // One clock of the architectural rules, applied to the inputs presented this cycle.
  function automatic void model_step();
    logic [31:0] pend;
    logic [31:0] wv;
    logic        ok;
    if (!rst_i) begin
      model_reset();
      return;
    end
    pend    = mip_word() & m_mie_r;
    ok      = (m_block == 0) && !x_stall_i && !x_kill_i;
    m_redir = 1'b0;
    if (m_block > 0) m_block = m_block - 1;
    if (ok && (x_exception_i || (m_st_mie && pend != 32'h0))) begin
      m_mepc    = d_pc_i & 32'hFFFF_FFFC;
      m_st_mpie = m_st_mie;
      m_st_mie  = 1'b0;
      if (x_exception_i) m_mcause = {28'h0, x_exception_cause_i};
      else               m_mcause = (pend & 32'h800) != 0 ? 32'h8000_000B : 32'h8000_0007;
      m_redir = 1'b1; m_pc = TV; m_block = FC + 1;
    end else if (ok && d_is_mret_i) begin
      m_st_mie  = m_st_mpie;
      m_st_mpie = 1'b1;
      m_redir = 1'b1; m_pc = m_mepc; m_block = FC + 1;
    end else if (ok && d_is_csr_i) begin
      wv = x_csr_write_value_i;
      case (d_csr_sel_i)
        12'h300: begin m_st_mie = wv[3]; m_st_mpie = wv[7]; end
        12'h304: m_mie_r  = wv & (TIMER_EN ? 32'h880 : 32'h800);
        12'h341: m_mepc   = wv & 32'hFFFF_FFFC;
        12'h342: m_mcause = wv & 32'h8000_000F;
        12'h344: m_mtip   = TIMER_EN & wv[7];
        default: begin end
      endcase
    end
    if (TIMER_EN && timer_tick_i) m_mtip = 1'b1;
  endfunction

  function automatic logic [192:0] exp_vec();
    logic [31:0] st;
    st = 32'h1800 | (m_st_mpie ? 32'h80 : 32'h0) | (m_st_mie ? 32'h8 : 32'h0);
    exp_vec = {st, mip_word(), m_mie_r, m_mepc, m_mcause, m_redir, m_redir ? m_pc : 32'h0};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    x_stall_i = 0; x_kill_i = 0; d_pc_i = 32'h0; d_is_csr_i = 0; d_csr_sel_i = 12'h0;
    x_csr_write_value_i = 32'h0; d_is_mret_i = 0; x_exception_i = 0;
    x_exception_cause_i = 4'h0; irq_i = 0; timer_tick_i = 0;
  endtask

  task automatic csr_write(input logic [11:0] sel, input logic [31:0] val);
    d_is_csr_i = 1; d_csr_sel_i = sel; x_csr_write_value_i = val;
    tick();
    d_is_csr_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++; if (csr_mstatus_o !== 32'h1800) $display("FAIL reset_mstatus got %h exp 00001800", csr_mstatus_o); else n_pass++;
    n_checks++; if ({csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o} !== 128'h0)
      $display("FAIL reset_csrs got %h %h %h %h exp all 0", csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o); else n_pass++;
    n_checks++; if (x_redirect_o !== 1'b0 || x_redirect_pc_o !== 32'h0)
      $display("FAIL reset_redirect got %b/%h exp 0/00000000", x_redirect_o, x_redirect_pc_o); else n_pass++;
    rst_i = 1;
    tick();
    n_checks++; if (x_redirect_o !== 1'b0) $display("FAIL post_reset_redirect got %b exp 0", x_redirect_o); else n_pass++;
  endtask

  task automatic test_irq_entry();
    csr_write(12'h300, 32'h8);
    csr_write(12'h304, 32'h800);
    n_checks++; if (csr_mie_o !== 32'h800) $display("FAIL mie_write got %h exp 00000800", csr_mie_o); else n_pass++;
    irq_i = 1; d_pc_i = 32'h100;
    tick();
    n_checks++; if (x_redirect_o !== 1'b1 || x_redirect_pc_o !== 32'h8)
      $display("FAIL irq_redirect got %b/%h exp 1/00000008", x_redirect_o, x_redirect_pc_o); else n_pass++;
    n_checks++; if (csr_mepc_o !== 32'h100) $display("FAIL irq_mepc got %h exp 00000100", csr_mepc_o); else n_pass++;
    n_checks++; if (csr_mcause_o !== 32'h8000_000B) $display("FAIL irq_mcause got %h exp 8000000b", csr_mcause_o); else n_pass++;
    n_checks++; if (csr_mstatus_o !== 32'h1880) $display("FAIL irq_mstatus got %h exp 00001880", csr_mstatus_o); else n_pass++;
    n_checks++; if (csr_mip_o !== 32'h800) $display("FAIL irq_mip got %h exp 00000800", csr_mip_o); else n_pass++;
    irq_i = 0;
    tick();
    n_checks++; if (x_redirect_o !== 1'b0) $display("FAIL irq_redirect_width got %b exp 0", x_redirect_o); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_mret();
    d_is_mret_i = 1;
    tick();
    d_is_mret_i = 0;
    n_checks++; if (x_redirect_o !== 1'b1 || x_redirect_pc_o !== 32'h100)
      $display("FAIL mret_redirect got %b/%h exp 1/00000100", x_redirect_o, x_redirect_pc_o); else n_pass++;
    n_checks++; if (csr_mstatus_o !== 32'h1888) $display("FAIL mret_mstatus got %h exp 00001888", csr_mstatus_o); else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_exc_priority();
    irq_i = 1; x_exception_i = 1; x_exception_cause_i = 4'd2; d_is_mret_i = 1; d_pc_i = 32'h207;
    tick();
    x_exception_i = 0; d_is_mret_i = 0; irq_i = 0;
    n_checks++; if (csr_mcause_o !== 32'h2) $display("FAIL exc_prio_mcause got %h exp 00000002", csr_mcause_o); else n_pass++;
    n_checks++; if (csr_mstatus_o !== 32'h1880) $display("FAIL exc_prio_mstatus got %h exp 00001880", csr_mstatus_o); else n_pass++;
    n_checks++; if (csr_mepc_o !== 32'h204) $display("FAIL exc_prio_mepc got %h exp 00000204", csr_mepc_o); else n_pass++;
    n_checks++; if (x_redirect_o !== 1'b1 || x_redirect_pc_o !== 32'h8)
      $display("FAIL exc_prio_redirect got %b/%h exp 1/00000008", x_redirect_o, x_redirect_pc_o); else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    // edge N: accepted
    x_exception_i = 1; x_exception_cause_i = 4'd3; d_pc_i = 32'h300;
    tick();
    n_checks++; if (x_redirect_o !== 1'b1 || csr_mcause_o !== 32'h3)
      $display("FAIL b2b_first got %b/%h exp 1/00000003", x_redirect_o, csr_mcause_o); else n_pass++;
    // edge N+1: redirect cycle, CSR write ignored
    x_exception_i = 0; d_is_csr_i = 1; d_csr_sel_i = 12'h341; x_csr_write_value_i = 32'hABC;
    tick();
    // edge N+2: second pulse refused
    d_is_csr_i = 0; x_exception_i = 1; x_exception_cause_i = 4'd11; d_pc_i = 32'h400;
    tick();
    n_checks++; if (x_redirect_o !== 1'b0 || csr_mcause_o !== 32'h3)
      $display("FAIL b2b_second got %b/%h exp 0/00000003", x_redirect_o, csr_mcause_o); else n_pass++;
    // edge N+3: CSR write during flush ignored
    x_exception_i = 0; d_is_csr_i = 1; d_csr_sel_i = 12'h341; x_csr_write_value_i = 32'h5550;
    tick();
    n_checks++; if (csr_mepc_o !== 32'h300) $display("FAIL b2b_flush_write got %h exp 00000300", csr_mepc_o); else n_pass++;
    // edge N+4: third pulse accepted
    d_is_csr_i = 0; x_exception_i = 1; x_exception_cause_i = 4'd2; d_pc_i = 32'h600;
    tick();
    n_checks++; if (x_redirect_o !== 1'b1 || csr_mcause_o !== 32'h2 || csr_mepc_o !== 32'h600)
      $display("FAIL b2b_third got %b/%h/%h exp 1/00000002/00000600", x_redirect_o, csr_mcause_o, csr_mepc_o); else n_pass++;
    x_exception_i = 0;
    tick();
    n_checks++; if (x_redirect_o !== 1'b0) $display("FAIL b2b_redirect_width got %b exp 0", x_redirect_o); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    x_exception_i = 1; x_exception_cause_i = 4'd3; d_pc_i = 32'h80;
    tick();
    x_exception_i = 0;
    n_checks++; if (x_redirect_o !== 1'b1) $display("FAIL arst_pre got %b exp 1", x_redirect_o); else n_pass++;
    #1 rst_i = 0;
    #1;
    n_checks++; if (x_redirect_o !== 1'b0 || csr_mcause_o !== 32'h0 || csr_mstatus_o !== 32'h1800)
      $display("FAIL arst_drop got %b/%h/%h exp 0/00000000/00001800", x_redirect_o, csr_mcause_o, csr_mstatus_o); else n_pass++;
    tick();
    rst_i = 1;
    x_exception_i = 1; x_exception_cause_i = 4'd11; d_pc_i = 32'h40;
    tick();
    x_exception_i = 0;
    n_checks++; if (x_redirect_o !== 1'b1 || csr_mcause_o !== 32'hB)
      $display("FAIL arst_idle got %b/%h exp 1/0000000b", x_redirect_o, csr_mcause_o); else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_timer();
`ifdef URV_TIMER_IRQ_EN
    timer_tick_i = 1;
    csr_write(12'h344, 32'h0);
    timer_tick_i = 0;
    n_checks++; if (csr_mip_o !== 32'h80) $display("FAIL timer_set_wins got %h exp 00000080", csr_mip_o); else n_pass++;
    csr_write(12'h344, 32'h0);
    n_checks++; if (csr_mip_o !== 32'h0) $display("FAIL timer_clear got %h exp 00000000", csr_mip_o); else n_pass++;
    csr_write(12'h304, 32'h80);
    csr_write(12'h300, 32'h8);
    timer_tick_i = 1;
    tick();
    timer_tick_i = 0;
    tick();
    n_checks++; if (x_redirect_o !== 1'b1 || csr_mcause_o !== 32'h8000_0007)
      $display("FAIL timer_irq got %b/%h exp 1/80000007", x_redirect_o, csr_mcause_o); else n_pass++;
    repeat (3) tick();
`else
    timer_tick_i = 1;
    csr_write(12'h344, 32'h80);
    timer_tick_i = 0;
    n_checks++; if (csr_mip_o !== 32'h0) $display("FAIL timer_off_mip got %h exp 00000000", csr_mip_o); else n_pass++;
    csr_write(12'h304, 32'h880);
    n_checks++; if (csr_mie_o !== 32'h800) $display("FAIL timer_off_mie got %h exp 00000800", csr_mie_o); else n_pass++;
`endif
  endtask

  function automatic logic [11:0] pick_sel(input int unsigned k);
    case (k)
      0: pick_sel = 12'h300;
      1: pick_sel = 12'h304;
      2: pick_sel = 12'h341;
      3: pick_sel = 12'h342;
      4: pick_sel = 12'h344;
      5: pick_sel = 12'h340;
      default: pick_sel = 12'h305;
    endcase
  endfunction

  task automatic test_random();
    logic [192:0] obs, exp;
    idle_inputs();
    rst_i = 0;
    tick();
    rst_i = 1;
    for (int i = 0; i < 3000; i++) begin
      rst_i               = ($urandom_range(0, 399) != 0);
      x_stall_i           = ($urandom_range(0, 7) == 0);
      x_kill_i            = ($urandom_range(0, 9) == 0);
      d_pc_i              = $urandom;
      d_is_csr_i          = ($urandom_range(0, 2) == 0);
      d_csr_sel_i         = pick_sel($urandom_range(0, 6));
      x_csr_write_value_i = $urandom;
      d_is_mret_i         = ($urandom_range(0, 7) == 0);
      x_exception_i       = ($urandom_range(0, 15) == 0);
      x_exception_cause_i = 4'($urandom);
      if ($urandom_range(0, 9) == 0) irq_i = ~irq_i;
      timer_tick_i        = ($urandom_range(0, 9) == 0);
      tick();
      exp = exp_vec();
      obs = {csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o,
             x_redirect_o, m_redir ? x_redirect_pc_o : 32'h0};
      n_checks++;
      if (obs !== exp) $display("FAIL random cycle %0d got %h exp %h", i, obs, exp);
      else n_pass++;
    end
    idle_inputs();
    rst_i = 1;
  endtask

  initial begin
    idle_inputs();
    rst_i = 0;
    test_reset();
    test_irq_entry();
    test_mret();
    test_exc_priority();
    test_back_to_back();
    test_async_reset();
    test_timer();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
